fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address and PC width in bits.
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 Parameter TIMEOUT, default 15, max cycles waiting for imem_ack (used only with FETCH_UNIT_TIMEOUT_EN).
REQ-004 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  ADDR_W  fetch address, equals pc.
REQ-008 imem_ack  input  1  memory returns imem_rdata valid this cycle.
REQ-009 imem_rdata  input  10  fetched 10-bit instruction word.
REQ-010 ir_d  output  10  instruction word to the downstream 10-bit instruction register D input.
REQ-011 ir_en  output  1  one-cycle write enable to the instruction register.
REQ-012 stall  input  1  execute stage busy; hold current instruction.
REQ-013 branch_valid  input  1  take branch at end of current instruction.
REQ-014 branch_target  input  ADDR_W  branch destination address.
REQ-015 halt  input  1  current instruction is HALT.
REQ-016 pc  output  ADDR_W  address of next instruction to fetch.
REQ-017 halted  output  1  high while in HALTED state.
REQ-018 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-019 FSM states SHALL be FETCH, ISSUE, EXEC, HALTED; state, pc, ir_d, ir_en, fetch_err all registered.
REQ-020 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on imem_req&&imem_ack, ir_d<=imem_rdata, pc<=pc+1 (mod 2^ADDR_W), next state ISSUE.
REQ-021 ISSUE: ir_en=1 for exactly one cycle, ir_d unchanged, next state EXEC; ir_en=0 in every other state.
REQ-022 EXEC with stall=1: remain in EXEC; pc, ir_d unchanged; branch_valid and halt ignored.
REQ-023 EXEC with stall=0: halt=1 -> HALTED (halt has priority over branch); else branch_valid=1 -> pc<=branch_target, FETCH; else FETCH with pc unchanged.
REQ-024 branch_valid, halt outside EXEC SHALL be ignored.
REQ-025 HALTED: imem_req=0, halted=1, all registers frozen; exit only via RST.
REQ-026 Latency: imem_ack sampled at edge N -> ir_en high during cycle N+1 -> earliest next imem_req at cycle N+3 (stall=0).
REQ-027 pc wraps from 2^ADDR_W-1 to 0 without error; branch_target wider bits not applicable (exact ADDR_W).
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 RST=1 asynchronously forces: state=FETCH, pc=RESET_PC, ir_d=10'b0, ir_en=0, fetch_err=0, watchdog count=0.
REQ-030 RST asserted mid-fetch or mid-stall aborts the operation; imem_req reasserts with imem_addr=RESET_PC on the first edge after RST deasserts.

Configuration
REQ-031 Macro FETCH_UNIT_TIMEOUT_EN defined: watchdog counts FETCH cycles without ack, cleared on ack; reaching TIMEOUT sets fetch_err=1 and enters HALTED.
REQ-032 Macro undefined: no watchdog logic, fetch_err tied 0, FETCH waits indefinitely.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the state enum, INSTR_W=10, default ADDR_W, RESET_PC.
REQ-034 One sub-module fetch_watchdog (counter + compare, instantiated only under FETCH_UNIT_TIMEOUT_EN); PC logic stays inline.

Verification
REQ-035 Reset release, memory acks in 1st cycle with 10'h2A5, stall=0 -> imem_addr=0x00, ir_d=10'h2A5, ir_en one cycle, next imem_addr=0x01.
REQ-036 Ack delayed 4 cycles -> imem_req and imem_addr=0x05 stable all 4 cycles; single ir_en pulse after ack.
REQ-037 stall=1 for 3 cycles with branch_valid=1, target 0x40 -> no fetch during stall; after stall drops next imem_addr=0x40.
REQ-038 pc=0xFF fetch, no branch -> next imem_addr=0x00; halt=1 with branch_valid=1 in EXEC -> halted=1, imem_req stays 0.
REQ-039 RST pulse mid-wait in FETCH at pc=0x12 -> outputs reset immediately; next request at RESET_PC.
REQ-040 FETCH_UNIT_TIMEOUT_EN, TIMEOUT=15, no ack -> fetch_err=1 and halted=1 after 15 FETCH cycles; macro off -> still requesting after 100 cycles, fetch_err=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its watchdog.
package fetch_pkg;

    localparam int INSTR_W        = 10;
    localparam int DEFAULT_ADDR_W = 8;
    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive un-acknowledged fetch cycles and flags when TIMEOUT is reached.
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // expired fires on the cycle whose edge would complete the TIMEOUT-th wait
    assign expired = count_en && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Four-state instruction fetch unit driving a 10-bit instruction register.
// Define FETCH_UNIT_TIMEOUT_EN to add the fetch watchdog and sticky fetch_err.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                TIMEOUT  = 15
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir_d,
    output logic               ir_en,
    input  logic               stall,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fetch_err
);

    fetch_state_t state;
    logic         handshake;
    logic         timeout_hit;

    assign handshake = imem_req && imem_ack;
    assign imem_addr = pc;

`ifdef FETCH_UNIT_TIMEOUT_EN
    logic wd_count_en;

    assign wd_count_en = (state == FETCH) && imem_req && !imem_ack;

    fetch_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .count_en(wd_count_en),
        .clear   (handshake),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // imem_req is held low during reset and raised on the first edge after release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir_d      <= '0;
            ir_en     <= 1'b0;
            imem_req  <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            ir_en <= 1'b0;
            case (state)
                FETCH: begin
                    if (handshake) begin
                        ir_d     <= imem_rdata;
                        pc       <= pc + ADDR_W'(1);
                        imem_req <= 1'b0;
                        ir_en    <= 1'b1;
                        state    <= ISSUE;
                    end else if (timeout_hit) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        halted    <= 1'b1;
                        state     <= HALTED;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    // halt outranks branch; both wait for the execute stage to finish
                    if (!stall) begin
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            if (branch_valid) begin
                                pc <= branch_target;
                            end
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters).
module tb_fetch_unit;

    logic       CLK;
    logic       RST;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [9:0] imem_rdata;
    logic [9:0] ir_d;
    logic       ir_en;
    logic       stall;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       halt;
    logic [7:0] pc;
    logic       halted;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir_d         (ir_d),
        .ir_en        (ir_en),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halt         (halt),
        .pc           (pc),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Completes one instruction starting from a FETCH cycle with imem_req high.
    task automatic run_instr(input logic [9:0] word, input logic br, input logic [7:0] tgt);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        tick();
        branch_valid  = br;
        branch_target = tgt;
        tick();
        branch_valid  = 1'b0;
        branch_target = 8'h00;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00", pc); end
        checks++; if (ir_d !== 10'h000) begin errors++; $display("[TB] FAIL reset_ir_d: got %h expected 000", ir_d); end
        checks++; if (ir_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_en: got %b expected 0", ir_en); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_err: got %b expected 0", fetch_err); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold_req: got %b expected 0", imem_req); end
        RST = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL release_addr: got %h expected 00", imem_addr); end
    endtask

    task automatic test_first_fetch();
        imem_ack   = 1'b1;
        imem_rdata = 10'h2A5;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 10'h000;
        checks++; if (ir_en !== 1'b1) begin errors++; $display("[TB] FAIL first_ir_en: got %b expected 1", ir_en); end
        checks++; if (ir_d !== 10'h2A5) begin errors++; $display("[TB] FAIL first_ir_d: got %h expected 2a5", ir_d); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL first_issue_req: got %b expected 0", imem_req); end
        checks++; if (pc !== 8'h01) begin errors++; $display("[TB] FAIL first_pc: got %h expected 01", pc); end
        tick();
        checks++; if (ir_en !== 1'b0) begin errors++; $display("[TB] FAIL first_ir_en_drop: got %b expected 0", ir_en); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL first_exec_req: got %b expected 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_next_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("[TB] FAIL first_next_addr: got %h expected 01", imem_addr); end
        checks++; if (ir_d !== 10'h2A5) begin errors++; $display("[TB] FAIL first_ir_d_hold: got %h expected 2a5", ir_d); end
    endtask

    task automatic test_delayed_ack();
        run_instr(10'h001, 1'b1, 8'h05);
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_req[%0d]: got %b expected 1", i, imem_req); end
            checks++; if (imem_addr !== 8'h05) begin errors++; $display("[TB] FAIL wait_addr[%0d]: got %h expected 05", i, imem_addr); end
            checks++; if (ir_en !== 1'b0) begin errors++; $display("[TB] FAIL wait_ir_en[%0d]: got %b expected 0", i, ir_en); end
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 10'h155;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir_en !== 1'b1) begin errors++; $display("[TB] FAIL delayed_ir_en: got %b expected 1", ir_en); end
        checks++; if (ir_d !== 10'h155) begin errors++; $display("[TB] FAIL delayed_ir_d: got %h expected 155", ir_d); end
        tick();
        checks++; if (ir_en !== 1'b0) begin errors++; $display("[TB] FAIL delayed_single_pulse: got %b expected 0", ir_en); end
        tick();
        checks++; if (imem_addr !== 8'h06) begin errors++; $display("[TB] FAIL delayed_next_addr: got %h expected 06", imem_addr); end
    endtask

    task automatic test_stall_branch();
        imem_ack   = 1'b1;
        imem_rdata = 10'h0AA;
        tick();
        imem_ack      = 1'b0;
        stall         = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 8'h40;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
            checks++; if (pc !== 8'h07) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected 07", i, pc); end
            tick();
        end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_end_req: got %b expected 0", imem_req); end
        stall = 1'b0;
        tick();
        branch_valid  = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL branch_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h40) begin errors++; $display("[TB] FAIL branch_addr: got %h expected 40", imem_addr); end
        // branch and halt while fetching must have no effect
        branch_valid  = 1'b1;
        branch_target = 8'h99;
        halt          = 1'b1;
        tick();
        branch_valid  = 1'b0;
        halt          = 1'b0;
        checks++; if (imem_addr !== 8'h40) begin errors++; $display("[TB] FAIL fetch_ignore_branch: got %h expected 40", imem_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL fetch_ignore_halt: got %b expected 0", halted); end
    endtask

    task automatic test_wrap_and_halt();
        run_instr(10'h002, 1'b1, 8'hFF);
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_start_addr: got %h expected ff", imem_addr); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected 00", pc); end
        tick();
        tick();
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL wrap_next_addr: got %h expected 00", imem_addr); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        halt          = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 8'h33;
        tick();
        halt          = 1'b0;
        branch_valid  = 1'b0;
        imem_ack      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halted[%0d]: got %b expected 1", i, halted); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halted_req[%0d]: got %b expected 0", i, imem_req); end
            checks++; if (pc !== 8'h01) begin errors++; $display("[TB] FAIL halted_pc[%0d]: got %h expected 01", i, pc); end
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        run_instr(10'h111, 1'b1, 8'h12);
        tick();
        tick();
        checks++; if (imem_addr !== 8'h12) begin errors++; $display("[TB] FAIL midreset_pre_addr: got %h expected 12", imem_addr); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL midreset_pc: got %h expected 00", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req: got %b expected 0", imem_req); end
        checks++; if (ir_d !== 10'h000) begin errors++; $display("[TB] FAIL midreset_ir_d: got %h expected 000", ir_d); end
        #2;
        RST = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL midreset_next_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL midreset_next_addr: got %h expected 00", imem_addr); end
    endtask

    task automatic test_timeout();
`ifdef FETCH_UNIT_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_halt[%0d]: got %b expected 0", i, halted); end
            tick();
        end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_err: got %b expected 0", fetch_err); end
        tick();
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", fetch_err); end
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL timeout_halted: got %b expected 1", halted); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_req: got %b expected 0", imem_req); end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL no_timeout_req: got %b expected 1", imem_req); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout_err: got %b expected 0", fetch_err); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout_halted: got %b expected 0", halted); end
`endif
    endtask

    initial begin
        RST           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 10'h000;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 8'h00;
        halt          = 1'b0;
        test_reset();
        test_first_fetch();
        test_delayed_ack();
        test_stall_branch();
        test_wrap_and_halt();
        test_reset_mid_fetch();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
